fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order memory requests, queues responses in a
// circular buffer and presents them to decode; stale responses after a flush are dropped.
module fetch_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            fetch_ready_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_ans_valid_i,
  input  logic [ILEN-1:0] mem_ans_instr_i,
  input  logic            mem_ans_except_i,
  output logic            mem_ans_ready_o,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output logic [ILEN-1:0] issue_instr_o,
  output logic [XLEN-1:0] issue_pc_o,
  output logic            issue_except_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]  pc_q     [DEPTH];
  logic [ILEN-1:0]  instr_q  [DEPTH];
  logic [DEPTH-1:0] except_q;
  logic [DEPTH-1:0] filled;

  logic [PW-1:0] head;
  logic [PW-1:0] fill;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] pend;
  logic [CW-1:0] drop_cnt;

  logic req_fire;
  logic ans_fire;
  logic fill_fire;
  logic iss_fire;
  logic flush_drop_dec;

  assign mem_req_valid_o = rst_n_i && !flush_i && (count < CW'(DEPTH));
  assign mem_req_addr_o  = pc_i;
  assign req_fire        = mem_req_valid_o && mem_req_ready_i;
  assign fetch_ready_o   = req_fire;

  assign mem_ans_ready_o = rst_n_i;
  assign ans_fire        = mem_ans_valid_i && mem_ans_ready_o;
  // A response with nothing to fill and nothing to drop is a protocol violation; ignore it.
  assign fill_fire       = ans_fire && (drop_cnt == '0) && (pend != '0);
  assign flush_drop_dec  = ans_fire && ((drop_cnt != '0) || (pend != '0));

  assign issue_valid_o   = rst_n_i && filled[head];
  assign issue_instr_o   = instr_q[head];
  assign issue_pc_o      = pc_q[head];
  assign issue_except_o  = except_q[head];
  assign iss_fire        = issue_valid_o && issue_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      pend     <= '0;
      drop_cnt <= '0;
      filled   <= '0;
    end else if (flush_i) begin
      // Every unfilled entry still has a response in flight that must be swallowed.
      head     <= '0;
      fill     <= '0;
      tail     <= '0;
      count    <= '0;
      pend     <= '0;
      filled   <= '0;
      drop_cnt <= drop_cnt + pend - CW'(flush_drop_dec);
    end else begin
      if (req_fire) begin
        pc_q[tail]   <= pc_i;
        filled[tail] <= 1'b0;
        tail         <= tail + PW'(1);
      end
      if (ans_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (fill_fire) begin
        instr_q[fill]  <= mem_ans_instr_i;
        except_q[fill] <= mem_ans_except_i;
        filled[fill]   <= 1'b1;
        fill           <= fill + PW'(1);
      end
      if (iss_fire) begin
        filled[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      count <= count + CW'(req_fire) - CW'(iss_fire);
      pend  <= pend + CW'(req_fire) - CW'(fill_fire);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: single fetch, backpressure,
// flush drop accounting, fault pass-through and mid-operation reset.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic [63:0] pc_i;
  logic        fetch_ready_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_ans_valid_i;
  logic [31:0] mem_ans_instr_i;
  logic        mem_ans_except_i;
  logic        mem_ans_ready_o;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_instr_o;
  logic [63:0] issue_pc_o;
  logic        issue_except_o;

  int checks = 0;
  int errors = 0;
  int accepted;

  fetch_stage #(.XLEN(64), .ILEN(32), .DEPTH(4)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .flush_i          (flush_i),
    .pc_i             (pc_i),
    .fetch_ready_o    (fetch_ready_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_ans_valid_i  (mem_ans_valid_i),
    .mem_ans_instr_i  (mem_ans_instr_i),
    .mem_ans_except_i (mem_ans_except_i),
    .mem_ans_ready_o  (mem_ans_ready_o),
    .issue_valid_o    (issue_valid_o),
    .issue_ready_i    (issue_ready_i),
    .issue_instr_o    (issue_instr_o),
    .issue_pc_o       (issue_pc_o),
    .issue_except_o   (issue_except_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic flush, input logic req_rdy, input logic ans_v,
                               input logic [31:0] instr, input logic exc,
                               input logic iss_rdy, input logic [63:0] pc);
    flush_i          = flush;
    mem_req_ready_i  = req_rdy;
    mem_ans_valid_i  = ans_v;
    mem_ans_instr_i  = instr;
    mem_ans_except_i = exc;
    issue_ready_i    = iss_rdy;
    pc_i             = pc;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got 1 expected 0");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst_n_i = 1'b0;
    applyStimulus(0, 1, 1, 32'h0, 0, 1, 64'h0);
    tick();
    tick();
    checkOutput("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    checkOutput("rst_fetch_ready", 64'(fetch_ready_o), 64'd0);
    checkOutput("rst_ans_ready", 64'(mem_ans_ready_o), 64'd0);
    checkOutput("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    rst_n_i = 1'b1;

    // Single fetch
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h1000);
    checkOutput("single_ans_ready", 64'(mem_ans_ready_o), 64'd1);
    checkOutput("single_req_valid", 64'(mem_req_valid_o), 64'd1);
    checkOutput("single_fetch_ready", 64'(fetch_ready_o), 64'd1);
    checkOutput("single_addr", mem_req_addr_o, 64'h1000);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 64'h1004);
    checkOutput("single_fetch_once", 64'(fetch_ready_o), 64'd0);
    tick();
    applyStimulus(0, 0, 1, 32'h00000013, 0, 0, 64'h1004);
    checkOutput("single_no_bypass", 64'(issue_valid_o), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h1004);
    checkOutput("single_issue_valid", 64'(issue_valid_o), 64'd1);
    checkOutput("single_issue_pc", issue_pc_o, 64'h1000);
    checkOutput("single_issue_instr", 64'(issue_instr_o), 64'h13);
    checkOutput("single_issue_exc", 64'(issue_except_o), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 64'h1004);
    checkOutput("single_empty", 64'(issue_valid_o), 64'd0);
    checkOutput("single_count", 64'(dut.count), 64'd0);

    // Backpressure: decode stalled, memory answers each accepted request a cycle later
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, (i >= 1 && i <= 4), 32'h10000000 + 32'(i), 0, 0, 64'h100 + 64'(4 * i));
      if (fetch_ready_o) accepted++;
      tick();
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd4);
    applyStimulus(0, 1, 0, 32'h0, 0, 1, 64'h200);
    checkOutput("bp_full_req_valid", 64'(mem_req_valid_o), 64'd0);
    checkOutput("bp_full_fetch_ready", 64'(fetch_ready_o), 64'd0);
    checkOutput("bp_issue_pc", issue_pc_o, 64'h100);
    checkOutput("bp_issue_instr", 64'(issue_instr_o), 64'h10000001);
    tick();
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h200);
    checkOutput("bp_one_more", 64'(fetch_ready_o), 64'd1);
    checkOutput("bp_one_more_addr", mem_req_addr_o, 64'h200);
    tick();
    applyStimulus(0, 1, 1, 32'h0000AAAA, 0, 1, 64'h204);
    checkOutput("bp_full_again", 64'(mem_req_valid_o), 64'd0);
    checkOutput("bp_drain0", issue_pc_o, 64'h104);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h204);
    checkOutput("bp_drain1", issue_pc_o, 64'h108);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h204);
    checkOutput("bp_drain2", issue_pc_o, 64'h10c);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h204);
    checkOutput("bp_drain3_pc", issue_pc_o, 64'h200);
    checkOutput("bp_drain3_instr", 64'(issue_instr_o), 64'hAAAA);
    checkOutput("bp_drain3_valid", 64'(issue_valid_o), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 64'h204);
    checkOutput("bp_empty", 64'(issue_valid_o), 64'd0);

    // Flush with three requests outstanding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h500 + 64'(4 * i));
      tick();
    end
    applyStimulus(1, 1, 0, 32'h0, 0, 0, 64'h50c);
    checkOutput("fl3_no_req", 64'(mem_req_valid_o), 64'd0);
    checkOutput("fl3_no_fetch", 64'(fetch_ready_o), 64'd0);
    tick();
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h2000);
    checkOutput("fl3_drop_cnt", 64'(dut.drop_cnt), 64'd3);
    checkOutput("fl3_count", 64'(dut.count), 64'd0);
    checkOutput("fl3_resume", 64'(fetch_ready_o), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 32'hDEAD0000 + 32'(i), 0, 1, 64'h2004);
      checkOutput("fl3_dropped", 64'(issue_valid_o), 64'd0);
      tick();
    end
    applyStimulus(0, 0, 1, 32'h00200013, 0, 0, 64'h2004);
    checkOutput("fl3_drained", 64'(dut.drop_cnt), 64'd0);
    checkOutput("fl3_still_empty", 64'(issue_valid_o), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h2004);
    checkOutput("fl3_new_valid", 64'(issue_valid_o), 64'd1);
    checkOutput("fl3_new_pc", issue_pc_o, 64'h2000);
    checkOutput("fl3_new_instr", 64'(issue_instr_o), 64'h00200013);
    tick();

    // Flush coinciding with a response, two outstanding
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h600);
    tick();
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h604);
    tick();
    applyStimulus(1, 1, 1, 32'h00000BAD, 0, 0, 64'h608);
    tick();
    applyStimulus(0, 1, 1, 32'h00000BAD, 0, 0, 64'h2100);
    checkOutput("fl2_drop_cnt", 64'(dut.drop_cnt), 64'd1);
    tick();
    applyStimulus(0, 0, 1, 32'h00300013, 0, 0, 64'h2104);
    checkOutput("fl2_dropped", 64'(issue_valid_o), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h2104);
    checkOutput("fl2_valid", 64'(issue_valid_o), 64'd1);
    checkOutput("fl2_pc", issue_pc_o, 64'h2100);
    checkOutput("fl2_instr", 64'(issue_instr_o), 64'h00300013);
    tick();

    // Access fault passes through to decode
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h3000);
    tick();
    applyStimulus(0, 1, 1, 32'hFFFFFFFF, 1, 0, 64'h3004);
    tick();
    applyStimulus(0, 0, 1, 32'h00000013, 0, 1, 64'h3008);
    checkOutput("fault_pc", issue_pc_o, 64'h3000);
    checkOutput("fault_exc", 64'(issue_except_o), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h3008);
    checkOutput("fault_next_pc", issue_pc_o, 64'h3004);
    checkOutput("fault_next_exc", 64'(issue_except_o), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 64'h3008);
    checkOutput("fault_empty", 64'(issue_valid_o), 64'd0);

    // Reset pulse with two filled entries
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h4000);
    tick();
    applyStimulus(0, 1, 1, 32'h00400013, 0, 0, 64'h4004);
    tick();
    applyStimulus(0, 0, 1, 32'h00400093, 0, 0, 64'h4008);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 64'h4008);
    checkOutput("rp_pre_valid", 64'(issue_valid_o), 64'd1);
    rst_n_i = 1'b0;
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h4008);
    checkOutput("rp_issue_valid", 64'(issue_valid_o), 64'd0);
    checkOutput("rp_req_valid", 64'(mem_req_valid_o), 64'd0);
    tick();
    rst_n_i = 1'b1;
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 64'h5000);
    checkOutput("rp_after_issue", 64'(issue_valid_o), 64'd0);
    checkOutput("rp_after_fetch", 64'(fetch_ready_o), 64'd1);
    checkOutput("rp_after_addr", mem_req_addr_o, 64'h5000);
    checkOutput("rp_after_drop", 64'(dut.drop_cnt), 64'd0);
    tick();
    applyStimulus(0, 0, 1, 32'h00500013, 0, 0, 64'h5004);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 1, 64'h5004);
    checkOutput("rp_first_valid", 64'(issue_valid_o), 64'd1);
    checkOutput("rp_first_pc", issue_pc_o, 64'h5000);
    checkOutput("rp_first_instr", 64'(issue_instr_o), 64'h00500013);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
